// File: rtl/mw_cook_controller.sv
// Microwave cook controller: keypad time entry, BCD MM:SS countdown,
// power-level duty cycling of the magnetron, pause/resume and done alarm.
// A prescaler derives the one-second tick from the system clock.
module mw_cook_controller #(
    parameter int CLK_DIV      = 100,
    parameter int POWER_PERIOD = 10,
    parameter int BEEP_SECS    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  keypad,
    input  logic        startn,
    input  logic        stopn,
    input  logic        clearn,
    input  logic        powern,
    input  logic        door_closed,
    output logic        mag_on,
    output logic [15:0] time_bcd,
    output logic [3:0]  power_level,
    output logic [2:0]  state,
    output logic        beep
);

    localparam int PS_W  = $clog2(CLK_DIV);
    localparam int PH_W  = $clog2(POWER_PERIOD + 1);
    localparam int BC_W  = $clog2(BEEP_SECS + 1);
    localparam int CMP_W = (PH_W > 4) ? PH_W : 4;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(POWER_PERIOD - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BEEP_SECS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_PWR    = 3'd2,
        ST_COOK   = 3'd3,
        ST_PAUSED = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // One-second BCD countdown with minute borrow; seconds 60..99 count linearly.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else if (st != 4'd0) begin
            st = st - 4'd1;
            so = 4'd9;
        end else begin
            st = 4'd5;
            so = 4'd9;
            if (mo != 4'd0) begin
                mo = mo - 4'd1;
            end else begin
                mo = 4'd9;
                mt = mt - 4'd1;
            end
        end
        return {mt, mo, st, so};
    endfunction

    // True when exactly one key line is active.
    function automatic logic is_one_hot(input logic [9:0] k);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 10; i++) begin
            cnt = cnt + {3'd0, k[i]};
        end
        return (cnt == 4'd1);
    endfunction

    // Digit value of the active key (meaningful only for a one-hot pattern).
    function automatic logic [3:0] key_digit(input logic [9:0] k);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) begin
                d = 4'(i);
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    state_t            state_r, state_next_s;
    logic [15:0]       time_r, time_next_s, time_dec_s;
    logic [3:0]        power_r, power_next_s;
    logic [PS_W-1:0]   ps_r, ps_next_s;
    logic [PH_W-1:0]   phase_r, phase_next_s;
    logic [BC_W-1:0]   bcnt_r, bcnt_next_s;
    logic              mag_r, mag_next_s;
    logic              beep_r, beep_next_s;

    logic start_prev_r, stop_prev_r, clear_prev_r, power_prev_r, key_prev_r;
    logic start_evt_s, stop_evt_s, clear_evt_s, power_evt_s, key_evt_s;
    logic [3:0] digit_s;
    logic time_zero_s, tick_s;

    // Previous button/key levels for press-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev_r <= 1'b1;
            stop_prev_r  <= 1'b1;
            clear_prev_r <= 1'b1;
            power_prev_r <= 1'b1;
            key_prev_r   <= 1'b0;
        end else begin
            start_prev_r <= startn;
            stop_prev_r  <= stopn;
            clear_prev_r <= clearn;
            power_prev_r <= powern;
            key_prev_r   <= |keypad;
        end
    end

    assign start_evt_s = start_prev_r & ~startn;
    assign stop_evt_s  = stop_prev_r  & ~stopn;
    assign clear_evt_s = clear_prev_r & ~clearn;
    assign power_evt_s = power_prev_r & ~powern;
    assign key_evt_s   = ~key_prev_r & (|keypad) & is_one_hot(keypad);
    assign digit_s     = key_digit(keypad);
    assign time_zero_s = (time_r == 16'h0000);
    assign time_dec_s  = bcd_dec(time_r);
    assign tick_s      = (ps_r == PS_LAST);

    // Next-state, countdown, prescaler and output decode.
    always_comb begin
        state_next_s = state_r;
        time_next_s  = time_r;
        power_next_s = power_r;
        ps_next_s    = ps_r;
        phase_next_s = phase_r;
        bcnt_next_s  = bcnt_r;

        case (state_r)
            ST_IDLE: begin
                if (clear_evt_s) begin
                    time_next_s = 16'h0000;
                end else if (power_evt_s) begin
                    state_next_s = ST_PWR;
                end else if (key_evt_s) begin
                    state_next_s = ST_ENTRY;
                    time_next_s  = {12'h000, digit_s};
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (clear_evt_s) begin
                    state_next_s = ST_IDLE;
                    time_next_s  = 16'h0000;
                end else if (start_evt_s && !time_zero_s && door_closed) begin
                    state_next_s = ST_COOK;
                    ps_next_s    = {PS_W{1'b0}};
                    phase_next_s = {PH_W{1'b0}};
                end else if (power_evt_s) begin
                    state_next_s = ST_PWR;
                end else if (key_evt_s) begin
                    time_next_s = {time_r[11:0], digit_s};
                end else begin
                    state_next_s = ST_ENTRY;
                end
            end
            ST_PWR: begin
                if (clear_evt_s) begin
                    state_next_s = ST_IDLE;
                    time_next_s  = 16'h0000;
                    power_next_s = 4'd10;
                end else if (key_evt_s) begin
                    power_next_s = (digit_s == 4'd0) ? 4'd10 : digit_s;
                    state_next_s = time_zero_s ? ST_IDLE : ST_ENTRY;
                end else begin
                    state_next_s = ST_PWR;
                end
            end
            ST_COOK: begin
                if (clear_evt_s) begin
                    state_next_s = ST_IDLE;
                    time_next_s  = 16'h0000;
                end else if (stop_evt_s || !door_closed) begin
                    // Prescaler and phase hold so the second resumes where it stopped.
                    state_next_s = ST_PAUSED;
                end else if (tick_s) begin
                    ps_next_s    = {PS_W{1'b0}};
                    time_next_s  = time_dec_s;
                    phase_next_s = (phase_r == PH_LAST) ? {PH_W{1'b0}} : phase_r + PH_W'(1);
                    if (time_dec_s == 16'h0000) begin
                        state_next_s = ST_DONE;
                        bcnt_next_s  = {BC_W{1'b0}};
                    end else begin
                        state_next_s = ST_COOK;
                    end
                end else begin
                    ps_next_s = ps_r + PS_W'(1);
                end
            end
            ST_PAUSED: begin
                if (clear_evt_s || stop_evt_s) begin
                    state_next_s = ST_IDLE;
                    time_next_s  = 16'h0000;
                end else if (start_evt_s && door_closed) begin
                    state_next_s = ST_COOK;
                end else begin
                    state_next_s = ST_PAUSED;
                end
            end
            ST_DONE: begin
                if (clear_evt_s || stop_evt_s || start_evt_s) begin
                    state_next_s = ST_IDLE;
                    time_next_s  = 16'h0000;
                end else if (tick_s) begin
                    ps_next_s = {PS_W{1'b0}};
                    if (bcnt_r == BC_LAST) begin
                        state_next_s = ST_IDLE;
                        time_next_s  = 16'h0000;
                    end else begin
                        bcnt_next_s = bcnt_r + BC_W'(1);
                    end
                end else begin
                    ps_next_s = ps_r + PS_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                time_next_s  = 16'h0000;
            end
        endcase

        // Magnetron only while staying in COOK, so leaving COOK drops it on the same edge.
        mag_next_s  = (state_r == ST_COOK) && (state_next_s == ST_COOK) && door_closed
                      && (CMP_W'(phase_next_s) < CMP_W'(power_next_s));
        beep_next_s = (state_next_s == ST_DONE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            time_r  <= 16'h0000;
            power_r <= 4'd10;
            ps_r    <= {PS_W{1'b0}};
            phase_r <= {PH_W{1'b0}};
            bcnt_r  <= {BC_W{1'b0}};
            mag_r   <= 1'b0;
            beep_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            time_r  <= time_next_s;
            power_r <= power_next_s;
            ps_r    <= ps_next_s;
            phase_r <= phase_next_s;
            bcnt_r  <= bcnt_next_s;
            mag_r   <= mag_next_s;
            beep_r  <= beep_next_s;
        end
    end

    assign mag_on      = mag_r;
    assign time_bcd    = time_r;
    assign power_level = power_r;
    assign state       = state_r;
    assign beep        = beep_r;

endmodule

// File: tb/tb_mw_cook_controller.sv
// Bench for mw_cook_controller: behavioural model (integer minutes/seconds,
// named states) checked every cycle, plus directed literal expectations.
module tb_mw_cook_controller;

    localparam int CLK_DIV = 4;
    localparam int PP      = 10;
    localparam int BEEPS   = 3;

    localparam int S_IDLE = 0, S_ENTRY = 1, S_PWR = 2, S_COOK = 3, S_PAUSED = 4, S_DONE = 5;

    logic        clk;
    logic        rst;
    logic [9:0]  keypad;
    logic        startn, stopn, clearn, powern, door_closed;
    logic        mag_on, beep;
    logic [15:0] time_bcd;
    logic [3:0]  power_level;
    logic [2:0]  state;

    int errors;
    int checks;

    // model state
    int m_state, m_mm, m_ss, m_power, m_sub, m_phase, m_bsec;
    bit m_mag, m_beep;
    bit p_start, p_stop, p_clear, p_power, p_key;

    mw_cook_controller #(
        .CLK_DIV(CLK_DIV),
        .POWER_PERIOD(PP),
        .BEEP_SECS(BEEPS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .keypad(keypad),
        .startn(startn),
        .stopn(stopn),
        .clearn(clearn),
        .powern(powern),
        .door_closed(door_closed),
        .mag_on(mag_on),
        .time_bcd(time_bcd),
        .power_level(power_level),
        .state(state),
        .beep(beep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] m_bcd(input int mm, input int ss);
        return 16'(((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10));
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task go_idle();
        m_state = S_IDLE;
        m_mm = 0;
        m_ss = 0;
    endtask

    // Advance the model by one clock using the inputs sampled at this edge.
    task model_step();
        bit e_start, e_stop, e_clear, e_power, e_key, zero;
        int d, prev;
        if (rst) begin
            go_idle();
            m_power = 10; m_sub = 0; m_phase = 0; m_bsec = 0; m_mag = 0; m_beep = 0;
            p_start = 1; p_stop = 1; p_clear = 1; p_power = 1; p_key = 0;
        end else begin
            e_start = p_start && !startn;
            e_stop  = p_stop && !stopn;
            e_clear = p_clear && !clearn;
            e_power = p_power && !powern;
            e_key   = !p_key && ($countones(keypad) == 1);
            d = 0;
            for (int i = 0; i < 10; i++) if (keypad[i]) d = i;
            prev = m_state;
            zero = (m_mm == 0 && m_ss == 0);
            case (m_state)
                S_IDLE: begin
                    if (e_clear) go_idle();
                    else if (e_power) m_state = S_PWR;
                    else if (e_key) begin m_state = S_ENTRY; m_ss = d; end
                end
                S_ENTRY: begin
                    if (e_clear) go_idle();
                    else if (e_start && !zero && door_closed) begin
                        m_state = S_COOK; m_sub = 0; m_phase = 0;
                    end else if (e_power) m_state = S_PWR;
                    else if (e_key) begin
                        m_mm = (m_mm % 10) * 10 + m_ss / 10;
                        m_ss = (m_ss % 10) * 10 + d;
                    end
                end
                S_PWR: begin
                    if (e_clear) begin go_idle(); m_power = 10; end
                    else if (e_key) begin
                        m_power = (d == 0) ? 10 : d;
                        m_state = zero ? S_IDLE : S_ENTRY;
                    end
                end
                S_COOK: begin
                    if (e_clear) go_idle();
                    else if (e_stop || !door_closed) m_state = S_PAUSED;
                    else begin
                        m_sub++;
                        if (m_sub == CLK_DIV) begin
                            m_sub = 0;
                            m_phase = (m_phase + 1) % PP;
                            if (m_ss > 0) m_ss--;
                            else begin m_ss = 59; m_mm--; end
                            if (m_mm == 0 && m_ss == 0) begin m_state = S_DONE; m_bsec = 0; end
                        end
                    end
                end
                S_PAUSED: begin
                    if (e_clear || e_stop) go_idle();
                    else if (e_start && door_closed) m_state = S_COOK;
                end
                S_DONE: begin
                    if (e_clear || e_stop || e_start) go_idle();
                    else begin
                        m_sub++;
                        if (m_sub == CLK_DIV) begin
                            m_sub = 0;
                            m_bsec++;
                            if (m_bsec == BEEPS) go_idle();
                        end
                    end
                end
                default: go_idle();
            endcase
            m_mag  = (prev == S_COOK) && (m_state == S_COOK) && door_closed && (m_phase < m_power);
            m_beep = (m_state == S_DONE);
            p_start = startn; p_stop = stopn; p_clear = clearn; p_power = powern;
            p_key = |keypad;
        end
    endtask

    // One clock: step the model at the edge, compare just after it.
    task cycle();
        @(posedge clk);
        model_step();
        #1;
        check("time_bcd", time_bcd, m_bcd(m_mm, m_ss));
        check("state", {13'd0, state}, 16'(m_state));
        check("power_level", {12'd0, power_level}, 16'(m_power));
        check("mag_on", {15'd0, mag_on}, {15'd0, m_mag});
        check("beep", {15'd0, beep}, {15'd0, m_beep});
    endtask

    task cycles(input int n);
        repeat (n) cycle();
    endtask

    task tap_key(input int d);
        keypad = 10'(1 << d);
        cycle();
        keypad = 10'd0;
        cycle();
    endtask

    task tap_start();
        startn = 1'b0; cycle(); startn = 1'b1;
    endtask

    task tap_stop();
        stopn = 1'b0; cycle(); stopn = 1'b1;
    endtask

    task tap_clear();
        clearn = 1'b0; cycle(); clearn = 1'b1;
    endtask

    task tap_power();
        powern = 1'b0; cycle(); powern = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        keypad = 10'd0;
        startn = 1'b1; stopn = 1'b1; clearn = 1'b1; powern = 1'b1;
        door_closed = 1'b1;
        cycles(2);
        rst = 1'b0;
        check("lit_reset_time", time_bcd, 16'h0000);
        check("lit_reset_power", {12'd0, power_level}, 16'd10);
        check("lit_reset_state", {13'd0, state}, 16'd0);
        check("lit_reset_mag", {15'd0, mag_on}, 16'd0);

        // cook 1:30 to done
        tap_key(1); tap_key(3); tap_key(0);
        check("lit_entry_0130", time_bcd, 16'h0130);
        tap_start();
        check("lit_cook_state", {13'd0, state}, 16'd3);
        cycle();
        check("lit_cook_mag", {15'd0, mag_on}, 16'd1);
        cycles(3);
        check("lit_first_tick", time_bcd, 16'h0129);
        cycles(120);
        check("lit_31_ticks", time_bcd, 16'h0059);
        cycles(236);
        check("lit_done_state", {13'd0, state}, 16'd5);
        check("lit_done_beep", {15'd0, beep}, 16'd1);
        check("lit_done_mag", {15'd0, mag_on}, 16'd0);
        cycles(11);
        check("lit_beep_hold", {15'd0, beep}, 16'd1);
        cycle();
        check("lit_beep_idle", {13'd0, state}, 16'd0);

        // five digits shift out the oldest
        tap_key(1); tap_key(2); tap_key(3); tap_key(4); tap_key(5);
        check("lit_shift_2345", time_bcd, 16'h2345);
        tap_start();
        cycles(184);
        check("lit_minute_borrow", time_bcd, 16'h2259);
        tap_clear();

        // power 3 duty cycle
        tap_power(); tap_key(3);
        check("lit_power3", {12'd0, power_level}, 16'd3);
        tap_key(2); tap_key(0);
        tap_start();
        cycles(11);
        check("lit_phase2_on", {15'd0, mag_on}, 16'd1);
        cycle();
        check("lit_phase3_off", {15'd0, mag_on}, 16'd0);
        cycles(28);
        check("lit_phase0_on", {15'd0, mag_on}, 16'd1);
        cycles(40);
        check("lit_p3_done", {13'd0, state}, 16'd5);
        tap_stop();

        // door open pauses, resume keeps prescaler
        tap_clear();
        tap_key(1); tap_key(0);
        tap_start();
        cycles(12);
        check("lit_0007", time_bcd, 16'h0007);
        cycle();
        door_closed = 1'b0;
        cycle();
        check("lit_paused", {13'd0, state}, 16'd4);
        check("lit_paused_mag", {15'd0, mag_on}, 16'd0);
        door_closed = 1'b1;
        cycles(2);
        check("lit_no_autoresume", {13'd0, state}, 16'd4);
        tap_start();
        cycles(2);
        check("lit_resume_hold", time_bcd, 16'h0007);
        cycle();
        check("lit_resume_tick", time_bcd, 16'h0006);
        tap_clear();

        // ignored starts and multi-hot keys
        tap_start();
        check("lit_start_zero", {13'd0, state}, 16'd0);
        tap_key(5);
        door_closed = 1'b0;
        tap_start();
        check("lit_start_door_open", {13'd0, state}, 16'd1);
        door_closed = 1'b1;
        keypad = 10'h003; cycle(); keypad = 10'd0; cycle();
        check("lit_multihot", time_bcd, 16'h0005);
        tap_clear();

        // reset mid-cook, clear beats start
        tap_power(); tap_key(5);
        check("lit_power5", {12'd0, power_level}, 16'd5);
        tap_key(9);
        tap_start();
        cycles(6);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("lit_rst_power", {12'd0, power_level}, 16'd10);
        check("lit_rst_state", {13'd0, state}, 16'd0);
        tap_key(4);
        startn = 1'b0; clearn = 1'b0; cycle(); startn = 1'b1; clearn = 1'b1;
        check("lit_clear_wins", {13'd0, state}, 16'd0);

        // randomized traffic
        for (int n = 0; n < 5000; n++) begin
            startn = ($urandom_range(0, 99) >= 4);
            stopn  = ($urandom_range(0, 99) >= 2);
            clearn = ($urandom_range(0, 199) >= 1);
            powern = ($urandom_range(0, 99) >= 2);
            case ($urandom_range(0, 19))
                0, 1:    keypad = 10'(1 << $urandom_range(0, 9));
                2:       keypad = 10'($urandom());
                default: keypad = 10'd0;
            endcase
            if ($urandom_range(0, 49) == 0) door_closed = ~door_closed;
            rst = ($urandom_range(0, 999) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
